// File: rtl/preproc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : preproc_pkg
//  Brief    : Shared types and defaults for the preprocessing frame sequencer
//  Revision : 1.0 - initial release
// ============================================================================
package preproc_pkg;

    localparam int c_RGB565_W       = 16;
    localparam int c_DEF_IMG_WIDTH  = 640;
    localparam int c_DEF_IMG_HEIGHT = 480;

    typedef logic [c_RGB565_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        ACTIVE   = 3'd2,
        PAD      = 3'd3,
        DROP     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/preproc_pos_counter.sv
`default_nettype none
// ============================================================================
//  Module   : preproc_pos_counter
//  Brief    : Column/row counter for the frame sequencer. Holds the position
//             of the next pixel to be emitted; i_clr restarts at (0,0) and
//             combines with i_x_inc / i_line_inc in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module preproc_pos_counter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int X_W        = 10,
    parameter int Y_W        = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clr,
    input  logic           i_x_inc,
    input  logic           i_line_inc,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last_col,
    output logic           o_last_row
);

    localparam logic [X_W-1:0] c_X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] c_Y_LAST = Y_W'(IMG_HEIGHT - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] w_base_x;
    logic [Y_W-1:0] w_base_y;

    // A restart replaces the stored position before any increment applies
    always_comb begin
        w_base_x = i_clr ? '0 : r_x;
        w_base_y = i_clr ? '0 : r_y;
    end

    // Position update: end of line wins over a column step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_line_inc) begin
            r_x <= '0;
            r_y <= (w_base_y == c_Y_LAST) ? '0 : w_base_y + 1'b1;
        end else begin
            r_x <= i_x_inc ? w_base_x + 1'b1 : w_base_x;
            r_y <= w_base_y;
        end
    end

    assign o_x        = r_x;
    assign o_y        = r_y;
    assign o_last_col = (r_x == c_X_LAST);
    assign o_last_row = (r_y == c_Y_LAST);

endmodule
`default_nettype wire

// File: rtl/preproc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : preproc_frame_sequencer
//  Brief    : Locks the camera pixel stream to frame start and emits exactly
//             IMG_WIDTH x IMG_HEIGHT pixels per frame into the RGB565
//             preprocessing stage (short lines padded, long lines truncated,
//             mid-frame sof flushes the stage).
//             Optional macro PREPROC_FRAME_SKIP_EN: forward 1 of skip_n+1
//             frames; without it skip_n is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module preproc_frame_sequencer
    import preproc_pkg::*;
#(
    parameter int IMG_WIDTH  = c_DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = c_DEF_IMG_HEIGHT,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [c_RGB565_W-1:0] cam_pixel,
    input  logic                  cam_valid,
    input  logic                  cam_sof,
    input  logic                  cam_eol,
    input  logic [3:0]            skip_n,
    output logic [c_RGB565_W-1:0] pp_pixel,
    output logic                  pp_valid,
    output logic                  pp_flush,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic [9:0]            x_pos,
    output logic [8:0]            y_pos,
    output logic                  busy,
    output logic [ERR_W-1:0]      err_count
);

    localparam int               c_X_W     = 10;
    localparam int               c_Y_W     = 9;
    localparam logic             c_W_ONE   = (IMG_WIDTH == 1);
    localparam logic             c_H_ONE   = (IMG_HEIGHT == 1);
    localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};

    state_t           r_state, w_next;
    logic             w_sof_px;
    logic             w_take, w_line_end, w_fwd, w_pad;
    logic             w_start, w_flush, w_done, w_err;
    logic             w_clr, w_x_inc, w_line_inc;
    logic             w_col_last, w_row_last;
    logic [c_X_W-1:0] w_x, w_out_x;
    logic [c_Y_W-1:0] w_y, w_out_y;
    logic             w_last_col, w_last_row;
    logic             w_suppress;

    pixel_t           r_pp_pixel;
    logic             r_pp_valid, r_pp_flush, r_frame_start, r_frame_done, r_busy;
    logic [c_X_W-1:0] r_x_pos;
    logic [c_Y_W-1:0] r_y_pos;
    logic [ERR_W-1:0] r_err_count;

    assign w_sof_px = cam_valid & cam_sof;

    preproc_pos_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .X_W        (c_X_W),
        .Y_W        (c_Y_W)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_x_inc    (w_x_inc),
        .i_line_inc (w_line_inc),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_last_col (w_last_col),
        .o_last_row (w_last_row)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and per-cycle actions. A taken pixel (normal or sof) goes
    // through one shared line-length check so sof+eol is handled as a resync
    // followed by a short line, and coincident error causes count once.
    always_comb begin
        w_next     = r_state;
        w_take     = 1'b0;
        w_line_end = 1'b0;
        w_fwd      = 1'b0;
        w_pad      = 1'b0;
        w_start    = 1'b0;
        w_flush    = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_clr      = 1'b0;
        w_x_inc    = 1'b0;
        w_line_inc = 1'b0;
        w_out_x    = w_x;
        w_out_y    = w_y;
        w_col_last = w_last_col;
        w_row_last = w_last_row;

        case (r_state)
            IDLE: begin
                if (enable) w_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!enable)       w_next = IDLE;
                else if (w_sof_px) w_take = 1'b1;
            end
            ACTIVE: begin
                if (cam_valid) begin
                    w_take = 1'b1;
                    if (cam_sof) begin
                        w_flush = 1'b1;
                        w_err   = 1'b1;
                    end
                end
            end
            PAD: begin
                if (w_sof_px) begin
                    w_take  = 1'b1;
                    w_flush = 1'b1;
                    w_err   = 1'b1;
                end else begin
                    w_pad = 1'b1;
                    if (cam_valid)  w_err      = 1'b1;
                    if (w_last_col) w_line_end = 1'b1;
                    else            w_x_inc    = 1'b1;
                end
            end
            DROP: begin
                if (w_sof_px) begin
                    w_take  = 1'b1;
                    w_flush = 1'b1;
                    w_err   = 1'b1;
                end else if (cam_valid && cam_eol) begin
                    w_line_end = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase

        if (w_take) begin
            w_fwd  = 1'b1;
            w_next = ACTIVE;
            if (cam_sof) begin
                w_start    = 1'b1;
                w_clr      = 1'b1;
                w_out_x    = '0;
                w_out_y    = '0;
                w_col_last = c_W_ONE;
                w_row_last = c_H_ONE;
            end
            if (cam_eol && w_col_last) begin
                w_line_end = 1'b1;
            end else if (cam_eol) begin
                w_err   = 1'b1;
                w_next  = PAD;
                w_x_inc = 1'b1;
            end else if (w_col_last) begin
                w_err  = 1'b1;
                w_next = DROP;
            end else begin
                w_x_inc = 1'b1;
            end
        end

        if (w_line_end) begin
            w_line_inc = 1'b1;
            if (w_row_last) begin
                w_done = 1'b1;
                w_next = enable ? WAIT_SOF : IDLE;
            end else begin
                w_next = ACTIVE;
            end
        end
    end

`ifdef PREPROC_FRAME_SKIP_EN
    logic [3:0] r_frame_cnt;
    logic [3:0] r_skip_n;

    // Decimation counter: advances per completed frame, wraps at the ratio latched at frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 4'd0;
            r_skip_n    <= 4'd0;
        end else begin
            if (w_start) r_skip_n <= skip_n;
            if (w_done)  r_frame_cnt <= (r_frame_cnt >= r_skip_n) ? 4'd0 : r_frame_cnt + 4'd1;
        end
    end

    assign w_suppress = (r_frame_cnt != 4'd0);
`else
    logic [3:0] w_unused_skip_n;
    assign w_unused_skip_n = skip_n;
    assign w_suppress      = 1'b0;
`endif

    // Output registers; pixel and position hold their last emitted value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pp_pixel    <= '0;
            r_pp_valid    <= 1'b0;
            r_pp_flush    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_x_pos       <= '0;
            r_y_pos       <= '0;
            r_busy        <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_pp_valid    <= (w_fwd | w_pad) & ~w_suppress;
            r_frame_start <= w_start & ~w_suppress;
            r_frame_done  <= w_done;
            r_pp_flush    <= w_flush;
            r_busy        <= (w_next != IDLE);
            if (w_fwd) r_pp_pixel <= cam_pixel;
            if (w_fwd | w_pad) begin
                r_x_pos <= w_out_x;
                r_y_pos <= w_out_y;
            end
            if (w_err && (r_err_count != c_ERR_MAX)) r_err_count <= r_err_count + 1'b1;
        end
    end

    assign pp_pixel    = r_pp_pixel;
    assign pp_valid    = r_pp_valid;
    assign pp_flush    = r_pp_flush;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign x_pos       = r_x_pos;
    assign y_pos       = r_y_pos;
    assign busy        = r_busy;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_preproc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_preproc_frame_sequencer
//  Brief    : Directed self-checking bench for preproc_frame_sequencer
//             (IMG_WIDTH=8, IMG_HEIGHT=4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_preproc_frame_sequencer;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] cam_pixel = 16'h0;
    logic        cam_valid = 1'b0;
    logic        cam_sof = 1'b0;
    logic        cam_eol = 1'b0;
    logic [3:0]  skip_n = 4'd0;
    logic [15:0] pp_pixel;
    logic        pp_valid, pp_flush, frame_start, frame_done, busy;
    logic [9:0]  x_pos;
    logic [8:0]  y_pos;
    logic [7:0]  err_count;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        en, v, sof, eol;
        logic [15:0] pix;
        logic        ev;
        logic [15:0] epix;
        logic        es, ed, ef;
        int          ex, ey, eerr;
        logic        ebusy;
    } vec_t;

    vec_t tbl[$];

    preproc_frame_sequencer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ERR_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cam_pixel   (cam_pixel),
        .cam_valid   (cam_valid),
        .cam_sof     (cam_sof),
        .cam_eol     (cam_eol),
        .skip_n      (skip_n),
        .pp_pixel    (pp_pixel),
        .pp_valid    (pp_valid),
        .pp_flush    (pp_flush),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .busy        (busy),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pv(input int x, input int y);
        return 16'h5000 + 16'(y * 16 + x);
    endfunction

    function automatic void push(input logic en, input logic v, input logic sof, input logic eol,
                                 input logic [15:0] pix, input logic ev, input logic [15:0] epix,
                                 input logic es, input logic ed, input logic ef,
                                 input int ex, input int ey, input int eerr, input logic ebusy);
        vec_t t;
        t.en = en; t.v = v; t.sof = sof; t.eol = eol; t.pix = pix;
        t.ev = ev; t.epix = epix; t.es = es; t.ed = ed; t.ef = ef;
        t.ex = ex; t.ey = ey; t.eerr = eerr; t.ebusy = ebusy;
        tbl.push_back(t);
    endfunction

    // Well-formed pixel: sof at (0,0), eol at last column, forwarded unchanged
    function automatic void add_norm(input int x, input int y, input logic en, input int err, input logic bsy);
        logic s, e, d;
        s = (x == 0) && (y == 0);
        e = (x == W - 1);
        d = (x == W - 1) && (y == H - 1);
        push(en, 1'b1, s, e, pv(x, y), 1'b1, pv(x, y), s, d, 1'b0, x, y, err, bsy);
    endfunction

    function automatic void add_gap(input logic en, input int err, input logic bsy);
        push(en, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 0, err, bsy);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic v, input logic sof, input logic eol, input logic [15:0] pix);
        @(negedge clk);
        enable = en; cam_valid = v; cam_sof = sof; cam_eol = eol; cam_pixel = pix;
        @(posedge clk);
        #1;
    endtask

    int cnt_v, cnt_s, cnt_d;

    initial begin
`ifdef PREPROC_FRAME_SKIP_EN
        skip_n = 4'd0;
`else
        skip_n = 4'd2;
`endif
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pp_valid", 0, pp_valid, 0);
        chk("reset_pp_pixel", 0, pp_pixel, 0);
        chk("reset_flush",    0, pp_flush, 0);
        chk("reset_start",    0, frame_start, 0);
        chk("reset_done",     0, frame_done, 0);
        chk("reset_x",        0, x_pos, 0);
        chk("reset_y",        0, y_pos, 0);
        chk("reset_busy",     0, busy, 0);
        chk("reset_err",      0, err_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- vector table ----------------
        // Frame A: clean 8x4 frame
        add_gap(1'b1, 0, 1'b1);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) add_norm(x, y, 1'b1, 0, 1'b1);
        add_gap(1'b1, 0, 1'b1);

        // Frame B: short line 1 (padded with 0x1234), long line 2 (truncated)
        for (int x = 0; x < W; x++) add_norm(x, 0, 1'b1, 0, 1'b1);
        for (int x = 0; x < 5; x++) begin
            logic [15:0] p;
            p = (x == 4) ? 16'h1234 : pv(x, 1);
            push(1'b1, 1'b1, 1'b0, x == 4, p, 1'b1, p, 1'b0, 1'b0, 1'b0, x, 1, (x == 4) ? 1 : 0, 1'b1);
        end
        for (int x = 5; x < W; x++)
            push(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, x, 1, 1, 1'b1);
        for (int x = 0; x < 11; x++) begin
            if (x < W)
                push(1'b1, 1'b1, 1'b0, 1'b0, pv(x, 2), 1'b1, pv(x, 2), 1'b0, 1'b0, 1'b0, x, 2,
                     (x == W - 1) ? 2 : 1, 1'b1);
            else
                push(1'b1, 1'b1, 1'b0, x == 10, pv(x, 2), 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 0, 2, 1'b1);
        end
        for (int x = 0; x < W; x++) add_norm(x, 3, 1'b1, 2, 1'b1);
        add_gap(1'b1, 2, 1'b1);

        // Frame C: resync sof at line 2, x=3
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < W; x++) add_norm(x, y, 1'b1, 2, 1'b1);
        for (int x = 0; x < 3; x++) add_norm(x, 2, 1'b1, 2, 1'b1);
        push(1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1, 0, 0, 3, 1'b1);
        for (int x = 1; x < W; x++) add_norm(x, 0, 1'b1, 3, 1'b1);
        for (int y = 1; y < H; y++)
            for (int x = 0; x < W; x++) add_norm(x, y, 1'b1, 3, 1'b1);
        add_gap(1'b1, 3, 1'b1);

        // Frame D: enable drops during line 1; frame still completes, then idle
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                add_norm(x, y, y == 0, 3, !((x == W - 1) && (y == H - 1)));
        add_gap(1'b0, 3, 1'b0);
        push(1'b0, 1'b1, 1'b1, 1'b0, pv(0, 0), 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1'b0);
        add_gap(1'b0, 3, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t t;
            t = tbl[i];
            step(t.en, t.v, t.sof, t.eol, t.pix);
            chk("pp_valid",    i, pp_valid, t.ev);
            chk("frame_start", i, frame_start, t.es);
            chk("frame_done",  i, frame_done, t.ed);
            chk("pp_flush",    i, pp_flush, t.ef);
            chk("err_count",   i, err_count, t.eerr);
            chk("busy",        i, busy, t.ebusy);
            if (t.ev) begin
                chk("pp_pixel", i, pp_pixel, t.epix);
                chk("x_pos",    i, x_pos, t.ex);
                chk("y_pos",    i, y_pos, t.ey);
            end
        end

        // ---------------- async reset mid-frame ----------------
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h7777);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h7778);
        chk("pre_rst_x", 0, x_pos, 1);
        @(negedge clk);
        cam_valid = 1'b0; cam_sof = 1'b0; cam_eol = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_pp_valid", 0, pp_valid, 0);
        chk("arst_pp_pixel", 0, pp_pixel, 0);
        chk("arst_x",        0, x_pos, 0);
        chk("arst_busy",     0, busy, 0);
        chk("arst_err",      0, err_count, 0);
        @(posedge clk);
        #1;
        chk("arst_flush", 0, pp_flush, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- sof+eol on one pixel ----------------
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0AAA);
        chk("se1_valid", 0, pp_valid, 1);
        chk("se1_start", 0, frame_start, 1);
        chk("se1_flush", 0, pp_flush, 0);
        chk("se1_err",   0, err_count, 1);
        for (int x = 1; x < W; x++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
            chk("se1_pad_valid", x, pp_valid, 1);
            chk("se1_pad_pixel", x, pp_pixel, 16'h0AAA);
            chk("se1_pad_x",     x, x_pos, x);
        end
        // Mid-frame sof+eol: resync and short line in one cycle count once
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0BBB);
        chk("se2_flush", 0, pp_flush, 1);
        chk("se2_start", 0, frame_start, 1);
        chk("se2_x",     0, x_pos, 0);
        chk("se2_y",     0, y_pos, 0);
        chk("se2_err",   0, err_count, 2);
        for (int x = 1; x < W; x++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("se2_pad_pixel", 0, pp_pixel, 16'h0BBB);
        chk("se2_pad_x",     0, x_pos, W - 1);

        // ---------------- error counter saturation ----------------
        for (int k = 0; k < 252; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0C00);
        chk("err_254", 0, err_count, 254);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0C00);
        chk("err_sat", 0, err_count, 255);

`ifdef PREPROC_FRAME_SKIP_EN
        // ---------------- frame decimation ----------------
        @(negedge clk);
        cam_valid = 1'b0; cam_sof = 1'b0; cam_eol = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        skip_n = 4'd2;
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int f = 0; f < 6; f++) begin
            cnt_v = 0; cnt_s = 0; cnt_d = 0;
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    step(1'b1, 1'b1, (x == 0) && (y == 0), x == W - 1, pv(x, y));
                    if (pp_valid)    cnt_v++;
                    if (frame_start) cnt_s++;
                    if (frame_done)  cnt_d++;
                end
            chk("skip_valid_cnt", f, cnt_v, (f % 3 == 0) ? 32 : 0);
            chk("skip_start_cnt", f, cnt_s, (f % 3 == 0) ? 1 : 0);
            chk("skip_done_cnt",  f, cnt_d, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
